// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bundle used on both sides of the SDRAM port arbiter.
// LANES parallel request lanes share one readdata bus; the client side
// uses one lane per GPU core, the SDRAM side a single lane.
interface sdram_port_arbiter_if #(
   parameter int LANES  = 1,
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic [LANES*ADDR_W-1:0] address;
   logic [LANES-1:0]        read;
   logic [LANES-1:0]        write;
   logic [LANES*DATA_W-1:0] writedata;
   logic [LANES-1:0]        waitrequest;
   logic [DATA_W-1:0]       readdata;
   logic [LANES-1:0]        readdatavalid;

   // The side that issues requests
   modport master (
      output address, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   // The side that services requests
   modport slave (
      input  address, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter merging PORT_COUNT Avalon-MM client ports onto one
// SDRAM master. A grant stalled by the SDRAM is locked until accepted so the
// bus stays stable. Pipelined reads are tracked in a tag FIFO, which steers
// each in-order return to the port that issued the read.
module sdram_port_arbiter #(
   parameter int          PORT_COUNT      = 4,
   parameter int          WORD_WIDTH      = 32,
   parameter int          ADDRESS_WIDTH   = 24,
   parameter int          MAX_OUTSTANDING = 8,
   parameter logic [31:0] SDRAM_BASE      = 32'h3E000000
) (
   input  logic                                 clock,
   input  logic                                 reset,
   sdram_port_arbiter_if.slave                  client,
   sdram_port_arbiter_if.master                 sdram,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 error
);

   localparam int IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [IDX_W-1:0] LAST_PORT  = IDX_W'(PORT_COUNT - 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic {
      ARB_FREE,
      ARB_LOCKED
   } arb_state_t;

   arb_state_t state_q, state_d;
   logic [IDX_W-1:0] held_q, held_d;
   logic [IDX_W-1:0] last_grant_q;

   // A port asserting read and write together gets its read serviced first;
   // this bit remembers that the read part has already gone out.
   logic [PORT_COUNT-1:0] read_served_q;

   logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic             error_q;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [PORT_COUNT-1:0] want_read;
   logic [PORT_COUNT-1:0] want_write;
   logic [PORT_COUNT-1:0] eligible;
   logic [IDX_W-1:0]      grant;
   logic                  presented;
   logic                  active;
   logic                  grant_is_read;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  spurious;
   logic [31:0]           byte_address;

   // Port index reached by stepping 'step' places past 'base', wrapping
   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                 input int step);
      return IDX_W'((int'(base) + step) % PORT_COUNT);
   endfunction

   // Which ports want what, and which may be granted given the FIFO level
   always_comb begin
      fifo_full  = (count_q == FULL_COUNT);
      fifo_empty = (count_q == '0);
      want_read  = '0;
      want_write = '0;
      eligible   = '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         want_read[i]  = client.read[i] & ~read_served_q[i];
         want_write[i] = client.write[i] & ~want_read[i];
         // A pending read (even one paired with a write) waits for FIFO room,
         // because the read part must go out before the write part.
         eligible[i]   = (want_read[i] & ~fifo_full) | want_write[i];
      end
   end

   // Grant choice: the held port while locked, otherwise round-robin scan
   always_comb begin
      grant     = held_q;
      presented = 1'b0;
      if (state_q == ARB_LOCKED) begin
         presented = eligible[held_q];
      end else begin
         // Scanning from the far end means the last hit is the nearest port
         for (int k = PORT_COUNT; k >= 1; k--) begin
            if (eligible[rr_index(last_grant_q, k)]) begin
               grant     = rr_index(last_grant_q, k);
               presented = 1'b1;
            end
         end
      end
   end

   // Master-side bus driven straight from the granted port
   always_comb begin
      active        = presented & ~reset;
      grant_is_read = want_read[grant];
      accept        = active & ~sdram.waitrequest[0];
      byte_address  = 32'(client.address[grant*ADDRESS_WIDTH +: ADDRESS_WIDTH]) + SDRAM_BASE;
      sdram.address   = '0;
      sdram.read      = '0;
      sdram.write     = '0;
      sdram.writedata = '0;
      if (active) begin
         sdram.address   = 30'(byte_address >> 2);
         sdram.read[0]   = grant_is_read;
         sdram.write[0]  = ~grant_is_read;
         sdram.writedata = client.writedata[grant*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   // Client-side stall, return steering and FIFO control strobes
   always_comb begin
      push     = accept & grant_is_read;
      pop      = sdram.readdatavalid[0] & ~fifo_empty;
      spurious = sdram.readdatavalid[0] & fifo_empty;
      client.waitrequest = '1;
      // The read half of a combined request is taken silently so the core
      // keeps holding the write until that too has been accepted.
      if (accept && !(grant_is_read && client.write[grant])) begin
         client.waitrequest[grant] = 1'b0;
      end
      client.readdata      = sdram.readdata;
      client.readdatavalid = '0;
      if (pop && !reset) begin
         client.readdatavalid[tag_mem[head_q]] = 1'b1;
      end
   end

   // Lock next-state: hold a stalled grant until it is accepted or abandoned
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      case (state_q)
         ARB_FREE: begin
            if (active && sdram.waitrequest[0]) begin
               state_d = ARB_LOCKED;
               held_d  = grant;
            end
         end
         ARB_LOCKED: begin
            if (!presented || !sdram.waitrequest[0]) begin
               state_d = ARB_FREE;
            end
         end
         default: state_d = ARB_FREE;
      endcase
   end

   // Lock state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARB_FREE;
         held_q  <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   // Round-robin pointer follows the most recently accepted port
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= LAST_PORT;
      end else if (accept) begin
         last_grant_q <= grant;
      end
   end

   // Track the read half of combined read+write requests
   always_ff @(posedge clock) begin
      if (reset) begin
         read_served_q <= '0;
      end else begin
         for (int i = 0; i < PORT_COUNT; i++) begin
            if (!client.write[i]) begin
               read_served_q[i] <= 1'b0;
            end else if (accept && grant == IDX_W'(i)) begin
               read_served_q[i] <= grant_is_read;
            end
         end
      end
   end

   // Tag FIFO: remember which port owns each read still in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tag_mem[tail_q] <= grant;
            tail_q          <= tail_q + 1'b1;
         end
         if (pop) begin
            head_q <= head_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Sticky flag for a return that no read was waiting for
   always_ff @(posedge clock) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (spurious) begin
         error_q <= 1'b1;
      end
   end

   assign outstanding = count_q;
   assign error       = error_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed vectors with literal checks,
// plus a queue-based reference model compared on every falling edge.
module tb_sdram_port_arbiter;

   localparam int          P    = 4;
   localparam int          AW   = 24;
   localparam int          DW   = 32;
   localparam int          MO   = 8;
   localparam logic [31:0] BASE = 32'h3E000000;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] outstanding;
   logic       error;

   int passed_count = 0;
   int total_count  = 0;

   sdram_port_arbiter_if #(.LANES(P), .ADDR_W(AW), .DATA_W(DW)) client_bus ();
   sdram_port_arbiter_if #(.LANES(1), .ADDR_W(30), .DATA_W(DW)) sdram_bus ();

   sdram_port_arbiter #(
      .PORT_COUNT(P), .WORD_WIDTH(DW), .ADDRESS_WIDTH(AW),
      .MAX_OUTSTANDING(MO), .SDRAM_BASE(BASE)
   ) dut (
      .clock(clock), .reset(reset), .client(client_bus), .sdram(sdram_bus),
      .outstanding(outstanding), .error(error)
   );

   always #5 clock = ~clock;

   // One comparison: count it, and report it if it does not match
   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      total_count++;
      if (actual === expected) passed_count++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   // Address and write data a port presents whenever it requests
   task automatic set_payload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      client_bus.address[i*AW +: AW]   = a;
      client_bus.writedata[i*DW +: DW] = d;
   endtask

   // Move to just after the next rising edge and drive one cycle of inputs
   task automatic apply_stimulus(input logic [P-1:0] rd, input logic [P-1:0] wr,
                                 input logic stall, input logic rdv, input logic rst);
      @(posedge clock);
      #1;
      reset                       = rst;
      client_bus.read             = rd;
      client_bus.write            = wr;
      sdram_bus.waitrequest[0]    = stall;
      sdram_bus.readdatavalid[0]  = rdv;
      sdram_bus.readdata          = $urandom();
      #1;
   endtask

   // Reference model state: pointer, lock, in-flight owner queue, error
   int m_last = P - 1;
   bit m_locked = 1'b0;
   int m_held = 0;
   int tagq[$];
   bit m_err = 1'b0;
   bit m_served [P];

   // Compute the required outputs from the arbitration rules, compare, advance
   always @(negedge clock) begin : model
      bit             full, is_rd, acc;
      bit             rd_want [P];
      bit             elig [P];
      int             g;
      logic [31:0]    a32;
      logic [29:0]    e_addr;
      logic           e_rd, e_wr;
      logic [DW-1:0]  e_wd;
      logic [P-1:0]   e_wait, e_rdv;
      full = (tagq.size() == MO);
      for (int i = 0; i < P; i++) begin
         rd_want[i] = client_bus.read[i] && !m_served[i];
         elig[i]    = (rd_want[i] && !full) || (client_bus.write[i] && !rd_want[i]);
      end
      g = -1;
      if (!reset) begin
         if (m_locked) begin
            if (elig[m_held]) g = m_held;
         end else begin
            for (int k = 1; k <= P; k++) begin
               if (elig[(m_last + k) % P]) begin
                  g = (m_last + k) % P;
                  break;
               end
            end
         end
      end
      e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0; is_rd = 1'b0;
      if (g >= 0) begin
         a32    = 32'(client_bus.address[g*AW +: AW]) + BASE;
         e_addr = a32[31:2];
         is_rd  = rd_want[g];
         e_rd   = is_rd;
         e_wr   = !is_rd;
         e_wd   = client_bus.writedata[g*DW +: DW];
      end
      acc    = (g >= 0) && !sdram_bus.waitrequest[0];
      e_wait = '1;
      if (acc && !(is_rd && client_bus.write[g])) e_wait[g] = 1'b0;
      e_rdv = '0;
      if (!reset && sdram_bus.readdatavalid[0] && tagq.size() > 0) e_rdv[tagq[0]] = 1'b1;

      check_output("sdram_address", sdram_bus.address, e_addr);
      check_output("sdram_read", sdram_bus.read, e_rd);
      check_output("sdram_write", sdram_bus.write, e_wr);
      check_output("sdram_writedata", sdram_bus.writedata, e_wd);
      check_output("port_waitrequest", client_bus.waitrequest, e_wait);
      check_output("port_readdatavalid", client_bus.readdatavalid, e_rdv);
      check_output("port_readdata", client_bus.readdata, sdram_bus.readdata);
      check_output("outstanding", outstanding, tagq.size());
      check_output("error", error, m_err);

      if (reset) begin
         m_last   = P - 1;
         m_locked = 1'b0;
         m_err    = 1'b0;
         tagq.delete();
         for (int i = 0; i < P; i++) m_served[i] = 1'b0;
      end else begin
         if (sdram_bus.readdatavalid[0]) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else m_err = 1'b1;
         end
         if (acc && is_rd) tagq.push_back(g);
         if (m_locked) begin
            if (g < 0 || !sdram_bus.waitrequest[0]) m_locked = 1'b0;
         end else if (g >= 0 && sdram_bus.waitrequest[0]) begin
            m_locked = 1'b1;
            m_held   = g;
         end
         if (acc) m_last = g;
         for (int i = 0; i < P; i++) begin
            if (!client_bus.write[i]) m_served[i] = 1'b0;
            else if (acc && g == i) m_served[i] = is_rd;
         end
      end
   end

   // Directed scenarios with hand-computed expectations
   initial begin : stimulus
      int rr_exp [6]    = '{3, 0, 1, 2, 3, 0};
      int drain_exp [8] = '{1, 2, 0, 1, 2, 0, 1, 0};
      reset                      = 1'b1;
      client_bus.read            = '0;
      client_bus.write           = '0;
      client_bus.address        = '0;
      client_bus.writedata      = '0;
      sdram_bus.waitrequest      = '0;
      sdram_bus.readdatavalid    = '0;
      sdram_bus.readdata         = '0;

      // Reset state
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
      check_output("reset_waitrequest", client_bus.waitrequest, 4'hF);
      check_output("reset_read", sdram_bus.read, 1'b0);
      check_output("reset_outstanding", outstanding, 4'd0);

      // Single read from port 2 and its return
      $display("[TB] single read");
      set_payload(2, 24'h000100, 32'h0);
      apply_stimulus(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("single_address", sdram_bus.address, 30'h0F800040);
      check_output("single_read", sdram_bus.read, 1'b1);
      check_output("single_waitrequest", client_bus.waitrequest, 4'b1011);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      sdram_bus.readdata = 32'hDEADBEEF;
      #1;
      check_output("single_outstanding", outstanding, 4'd1);
      check_output("single_rdv", client_bus.readdatavalid, 4'b0100);
      check_output("single_readdata", client_bus.readdata, 32'hDEADBEEF);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("single_drained", outstanding, 4'd0);

      // Round-robin among four writers, starting after port 2
      $display("[TB] round robin");
      for (int i = 0; i < P; i++) set_payload(i, 24'(i * 16), 32'h1000 + i);
      for (int c = 0; c < 6; c++) begin
         apply_stimulus(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
         check_output("rr_waitrequest", client_bus.waitrequest, 4'hF ^ (4'b0001 << rr_exp[c]));
         check_output("rr_writedata", sdram_bus.writedata, 32'h1000 + rr_exp[c]);
      end

      // Lock on port 1 while the SDRAM stalls, then port 3
      $display("[TB] grant lock");
      set_payload(1, 24'h000010, 32'hAAAA0001);
      set_payload(3, 24'h000030, 32'hBBBB0003);
      for (int c = 0; c < 3; c++) begin
         apply_stimulus(4'h0, 4'b1010, 1'b1, 1'b0, 1'b0);
         check_output("lock_address", sdram_bus.address, 30'h0F800004);
         check_output("lock_writedata", sdram_bus.writedata, 32'hAAAA0001);
         check_output("lock_waitrequest", client_bus.waitrequest, 4'hF);
      end
      apply_stimulus(4'h0, 4'b1010, 1'b0, 1'b0, 1'b0);
      check_output("lock_accept", client_bus.waitrequest, 4'b1101);
      apply_stimulus(4'h0, 4'b1000, 1'b0, 1'b0, 1'b0);
      check_output("lock_next_wait", client_bus.waitrequest, 4'b0111);
      check_output("lock_next_address", sdram_bus.address, 30'h0F80000C);

      // A locked port that drops its request releases the lock a cycle later
      set_payload(0, 24'h000040, 32'hC0C0C0C0);
      set_payload(2, 24'h000050, 32'hD2D2D2D2);
      apply_stimulus(4'h0, 4'b0001, 1'b1, 1'b0, 1'b0);
      apply_stimulus(4'h0, 4'b0100, 1'b1, 1'b0, 1'b0);
      check_output("drop_write", sdram_bus.write, 1'b0);
      apply_stimulus(4'h0, 4'b0100, 1'b0, 1'b0, 1'b0);
      check_output("drop_regrant", client_bus.waitrequest, 4'b1011);

      // Fill the FIFO, writes still pass, first return unblocks one read
      $display("[TB] fifo full");
      for (int c = 0; c < MO; c++) apply_stimulus(4'b0111, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0);
      check_output("full_count", outstanding, 4'd8);
      check_output("full_write_wait", client_bus.waitrequest, 4'b0111);
      apply_stimulus(4'b0111, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("full_pop_rdv", client_bus.readdatavalid, 4'b0001);
      check_output("full_blocked", sdram_bus.read, 1'b0);
      apply_stimulus(4'b0111, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("full_reopen_count", outstanding, 4'd7);
      check_output("full_reopen_wait", client_bus.waitrequest, 4'b1110);
      for (int c = 0; c < MO; c++) begin
         apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
         check_output("drain_rdv", client_bus.readdatavalid, 4'b0001 << drain_exp[c]);
      end
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("drain_empty", outstanding, 4'd0);

      // In-order returns for reads issued by ports 0,3,0,1
      $display("[TB] ordering");
      apply_stimulus(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b1000, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b0010, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("order_rdv0", client_bus.readdatavalid, 4'b0001);
      check_output("order_before", outstanding, 4'd3);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("order_push_pop", outstanding, 4'd3);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("order_rdv1", client_bus.readdatavalid, 4'b1000);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("order_rdv2", client_bus.readdatavalid, 4'b0001);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("order_rdv3", client_bus.readdatavalid, 4'b0010);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

      // Combined read+write on port 2: read goes first, write stays stalled
      $display("[TB] combined request");
      apply_stimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
      check_output("combo_read", sdram_bus.read, 1'b1);
      check_output("combo_read_wait", client_bus.waitrequest, 4'hF);
      apply_stimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
      check_output("combo_write", sdram_bus.write, 1'b1);
      check_output("combo_write_wait", client_bus.waitrequest, 4'b1011);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("combo_rdv", client_bus.readdatavalid, 4'b0100);

      // Spurious return, then reset mid-lock with three reads in flight
      $display("[TB] error and reset");
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("spurious_rdv", client_bus.readdatavalid, 4'b0000);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("spurious_error", error, 1'b1);
      apply_stimulus(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4'h0, 4'b1000, 1'b1, 1'b0, 1'b0);
      check_output("pre_reset_count", outstanding, 4'd3);
      apply_stimulus(4'h0, 4'b1000, 1'b1, 1'b0, 1'b1);
      check_output("in_reset_wait", client_bus.waitrequest, 4'hF);
      check_output("in_reset_write", sdram_bus.write, 1'b0);
      apply_stimulus(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
      check_output("post_reset_count", outstanding, 4'd0);
      check_output("post_reset_error", error, 1'b0);
      check_output("post_reset_grant", client_bus.waitrequest, 4'b1110);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      check_output("late_return_rdv", client_bus.readdatavalid, 4'b0000);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_output("late_return_error", error, 1'b1);
      apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

      @(posedge clock);
      #1;
      $display("%0d/%0d checks passed", passed_count, total_count);
      $finish;
   end

endmodule
